// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register responder.
package spi_reg_pkg;
    localparam int ADDR_W_DEF   = 7;
    localparam int CMD_READ_BIT = 7;

    typedef enum logic [1:0] {IDLE, CMD, WR, RD} state_e;
endpackage

// File: rtl/spi_pin_sync.sv
// Oversamples sck/cs_n/mosi into the system clock domain and produces
// registered single-cycle edge pulses plus aligned mosi and cs_n levels.
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sck,
    input  logic cs_n,
    input  logic mosi,
    output logic sck_rise,
    output logic sck_fall,
    output logic cs_fall,
    output logic cs_rise,
    output logic mosi_s,
    output logic cs_n_s
);
    logic [SYNC_STAGES-1:0] sck_q, cs_q, mosi_q;
    logic                   sck_d;

    // cs_n chain resets low so a frame already running at reset release
    // never looks like a high-then-low transition.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sck_q    <= '0;
            cs_q     <= '0;
            mosi_q   <= '0;
            sck_d    <= 1'b0;
            cs_n_s   <= 1'b0;
            sck_rise <= 1'b0;
            sck_fall <= 1'b0;
            cs_fall  <= 1'b0;
            cs_rise  <= 1'b0;
            mosi_s   <= 1'b0;
        end else begin
            sck_q    <= (sck_q << 1)  | SYNC_STAGES'(sck);
            cs_q     <= (cs_q << 1)   | SYNC_STAGES'(cs_n);
            mosi_q   <= (mosi_q << 1) | SYNC_STAGES'(mosi);
            sck_d    <= sck_q[SYNC_STAGES-1];
            cs_n_s   <= cs_q[SYNC_STAGES-1];
            sck_rise <= sck_q[SYNC_STAGES-1] & ~sck_d;
            sck_fall <= ~sck_q[SYNC_STAGES-1] & sck_d;
            cs_fall  <= ~cs_q[SYNC_STAGES-1] & cs_n_s;
            cs_rise  <= cs_q[SYNC_STAGES-1] & ~cs_n_s;
            mosi_s   <= mosi_q[SYNC_STAGES-1];
        end
    end
endmodule

// File: rtl/spi_reg_responder.sv
// SPI mode-0 responder: command byte (R/nW + address) followed by
// auto-incrementing byte writes or prefetched byte reads.
module spi_reg_responder
    import spi_reg_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              spi_sck,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic [ADDR_W-1:0] reg_addr,
    output logic              reg_wr_en,
    output logic [7:0]        reg_wr_data,
    output logic              reg_rd_en,
    input  logic [7:0]        reg_rd_data,
    output logic              busy,
    output logic              frame_err
);
    logic       sck_rise, sck_fall, cs_fall, cs_rise, mosi_s, cs_n_s;
    logic       active, armed, rd_load, wr_inc;
    logic [2:0] bit_cnt, cnt_nx;
    logic [7:0] rx_sr, tx_sr, rx_byte;
    state_e     state;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .sck      (spi_sck),
        .cs_n     (spi_cs_n),
        .mosi     (spi_mosi),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .cs_fall  (cs_fall),
        .cs_rise  (cs_rise),
        .mosi_s   (mosi_s),
        .cs_n_s   (cs_n_s)
    );

    // The cs_rise cycle still counts as selected so a byte completing on
    // that same clk is issued rather than flagged as partial.
    assign active   = (state != IDLE) && (!cs_n_s || cs_rise);
    assign rx_byte  = {rx_sr[6:0], mosi_s};
    assign cnt_nx   = (active && sck_rise) ? bit_cnt + 3'd1 : bit_cnt;
    assign spi_miso = tx_sr[7];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            rx_sr       <= '0;
            tx_sr       <= '0;
            armed       <= 1'b0;
            rd_load     <= 1'b0;
            wr_inc      <= 1'b0;
            reg_addr    <= '0;
            reg_wr_en   <= 1'b0;
            reg_wr_data <= '0;
            reg_rd_en   <= 1'b0;
            busy        <= 1'b0;
            spi_miso_oe <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            reg_wr_en <= 1'b0;
            reg_rd_en <= 1'b0;
            frame_err <= 1'b0;
            if (cs_n_s) armed <= 1'b1;
            if (wr_inc) begin
                reg_addr <= reg_addr + ADDR_W'(1);
                wr_inc   <= 1'b0;
            end
            if (rd_load) begin
                tx_sr   <= reg_rd_data;
                rd_load <= 1'b0;
            end

            if (active && sck_rise) begin
                bit_cnt <= cnt_nx;
                if (state != RD) rx_sr <= rx_byte;
                if (bit_cnt == 3'd7) begin
                    case (state)
                        CMD: begin
                            reg_addr <= rx_byte[ADDR_W-1:0];
                            if (rx_byte[CMD_READ_BIT]) begin
                                reg_rd_en <= 1'b1;
                                rd_load   <= 1'b1;
                                state     <= RD;
                            end else begin
                                state <= WR;
                            end
                        end
                        WR: begin
                            reg_wr_en   <= 1'b1;
                            reg_wr_data <= rx_byte;
                            wr_inc      <= 1'b1;
                        end
                        RD: begin
                            reg_addr  <= reg_addr + ADDR_W'(1);
                            reg_rd_en <= 1'b1;
                            rd_load   <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end

            // The fall that closes a byte keeps the freshly loaded MSB on the line.
            if (active && sck_fall && state == RD && bit_cnt != 3'd0)
                tx_sr <= {tx_sr[6:0], 1'b0};

            if (cs_rise) begin
                if (state != IDLE && cnt_nx != 3'd0) frame_err <= 1'b1;
                state       <= IDLE;
                bit_cnt     <= '0;
                tx_sr       <= '0;
                rd_load     <= 1'b0;
                wr_inc      <= 1'b0;
                busy        <= 1'b0;
                spi_miso_oe <= 1'b0;
            end else if (cs_fall && armed && state == IDLE) begin
                state       <= CMD;
                bit_cnt     <= '0;
                tx_sr       <= '0;
                busy        <= 1'b1;
                spi_miso_oe <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_spi_reg_responder.sv
// Directed bench: frame-level model predicts strobes, MISO bytes and errors.
`timescale 1ns/1ps
module tb_spi_reg_responder;
    localparam int ADDR_W      = 7;
    localparam int SYNC_STAGES = 2;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              spi_sck, spi_cs_n, spi_mosi;
    logic              spi_miso, spi_miso_oe;
    logic [ADDR_W-1:0] reg_addr;
    logic              reg_wr_en, reg_rd_en, busy, frame_err;
    logic [7:0]        reg_wr_data, reg_rd_data;

    int n_pass = 0, n_fail = 0;
    int cyc = 0, rise_cyc = 0, err_seen = 0, exp_err = 0;
    int exp_wr[$];   // addr*256 + data
    int exp_rd[$];   // addresses
    int exp_miso[$]; // bytes expected on MISO after the command byte

    spi_reg_responder #(.ADDR_W(ADDR_W), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .spi_sck     (spi_sck),
        .spi_cs_n    (spi_cs_n),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .reg_addr    (reg_addr),
        .reg_wr_en   (reg_wr_en),
        .reg_wr_data (reg_wr_data),
        .reg_rd_en   (reg_rd_en),
        .reg_rd_data (reg_rd_data),
        .busy        (busy),
        .frame_err   (frame_err)
    );

    // Register file content: data = addr ^ 0xFF
    assign reg_rd_data = {1'b0, reg_addr} ^ 8'hFF;

    always #10.417 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        if (act === exp) n_pass++;
        else begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Frame model: fr holds bytes MSB-first (fr[31:24] is the command).
    task automatic model(input logic [31:0] fr, input int nbits);
        int nfull, addr, npart;
        logic [7:0] b;
        nfull = nbits / 8;
        if (nbits % 8 != 0) exp_err++;
        if (nfull < 1) return;
        b = fr[31 -: 8];
        addr = int'(b[6:0]);
        if (b[7]) begin
            for (int k = 0; k < nfull; k++) exp_rd.push_back((addr + k) % 128);
            npart = (nbits - 8 + 7) / 8;
            for (int j = 0; j < npart; j++) exp_miso.push_back(((addr + j) % 128) ^ 8'hFF);
        end else begin
            for (int j = 0; j < nfull - 1; j++) begin
                b = fr[23 - 8*j -: 8];
                exp_wr.push_back(((addr + j) % 128) * 256 + int'(b));
            end
        end
    endtask

    task automatic send_bit(input logic b, input bit chk_miso, input int expb);
        spi_mosi = b;
        clk_n(4);
        if (chk_miso) chk("miso_bit", int'(spi_miso), expb);
        spi_sck  = 1'b1;
        rise_cyc = cyc;
        clk_n(4);
        spi_sck  = 1'b0;
    endtask

    task automatic frame(input logic [31:0] fr, input int nbits, input int gap);
        int n, e;
        bit rd;
        rd = fr[31];
        spi_cs_n = 1'b0;
        clk_n(8);
        chk("busy_on", int'(busy), 1);
        chk("oe_on", int'(spi_miso_oe), 1);
        for (int i = 0; i < nbits; i++) begin
            e = 0;
            if (rd && i >= 8) e = (exp_miso[(i - 8) / 8] >> (7 - (i % 8))) & 1;
            send_bit(fr[31 - i], rd && i >= 8, e);
        end
        clk_n(4);
        spi_cs_n = 1'b1;
        n = 0;
        while (busy && n < 12) begin
            clk_n(1);
            n++;
        end
        chk("busy_fall_lat_ok", int'(n <= SYNC_STAGES + 2), 1);
        chk("oe_off", int'(spi_miso_oe), 0);
        chk("miso_idle", int'(spi_miso), 0);
        exp_miso.delete();
        clk_n(gap);
    endtask

    task automatic end_test(input string name);
        chk({name, "_wr_left"}, exp_wr.size(), 0);
        chk({name, "_rd_left"}, exp_rd.size(), 0);
        chk({name, "_frame_err"}, err_seen, exp_err);
        exp_wr.delete();
        exp_rd.delete();
        err_seen = 0;
        exp_err  = 0;
    endtask

    // Compare process: every strobe is matched against the model queues.
    always @(negedge clk) begin
        if (reset_n) begin
            if (reg_wr_en || reg_rd_en)
                chk("wr_rd_exclusive", int'(reg_wr_en & reg_rd_en), 0);
            if (reg_wr_en) begin
                chk("wr_expected", int'(exp_wr.size() > 0), 1);
                if (exp_wr.size() > 0)
                    chk("wr_addr_data", int'({reg_addr, reg_wr_data}), exp_wr.pop_front());
                chk("wr_latency", cyc - rise_cyc, SYNC_STAGES + 2);
            end
            if (reg_rd_en) begin
                chk("rd_expected", int'(exp_rd.size() > 0), 1);
                if (exp_rd.size() > 0) chk("rd_addr", int'(reg_addr), exp_rd.pop_front());
            end
            if (frame_err) err_seen++;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n  = 1'b0;
        spi_cs_n = 1'b1;
        spi_sck  = 1'b0;
        spi_mosi = 1'b0;
        clk_n(3);
        chk("rst_oe", int'(spi_miso_oe), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_strobes", int'({reg_wr_en, reg_rd_en, frame_err}), 0);
        chk("rst_addr", int'(reg_addr), 0);
        reset_n = 1'b1;
        clk_n(10);

        // Write burst
        model(32'h05A53C00, 24);
        chk("pin_wr0", exp_wr[0], 'h05A5);
        chk("pin_wr1", exp_wr[1], 'h063C);
        frame(32'h05A53C00, 24, 10);
        end_test("write");

        // Read burst
        model(32'h90000000, 24);
        chk("pin_rd2", exp_rd[2], 'h12);
        chk("pin_miso0", exp_miso[0], 'hEF);
        chk("pin_miso1", exp_miso[1], 'hEE);
        frame(32'h90000000, 24, 10);
        end_test("read");

        // Address wrap
        model(32'h7F010200, 24);
        chk("pin_wrap", exp_wr[1], 'h0002);
        frame(32'h7F010200, 24, 10);
        end_test("wrap");

        // Abort mid-byte
        model(32'h40123400, 21);
        chk("pin_abort_err", exp_err, 1);
        frame(32'h40123400, 21, 10);
        end_test("abort");

        // Back-to-back frames
        model(32'h33440000, 16);
        frame(32'h33440000, 16, 6);
        model(32'h8A000000, 16);
        frame(32'h8A000000, 16, 10);
        end_test("b2b");

        // Reset during a read, released with CS still low
        model(32'h90000000, 8);
        spi_cs_n = 1'b0;
        clk_n(8);
        for (int i = 0; i < 8; i++) send_bit(((8'h90 >> (7 - i)) & 1) != 0, 1'b0, 0);
        for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b0, 0);
        reset_n = 1'b0;
        #1;
        chk("rst_async_oe", int'(spi_miso_oe), 0);
        clk_n(3);
        reset_n = 1'b1;
        for (int i = 0; i < 16; i++) send_bit(i[0], 1'b0, 0);
        clk_n(4);
        chk("rst_frame_oe", int'(spi_miso_oe), 0);
        chk("rst_frame_busy", int'(busy), 0);
        spi_cs_n = 1'b1;
        clk_n(10);
        end_test("midreset");
        model(32'h20110000, 16);
        frame(32'h20110000, 16, 10);
        end_test("resume");

        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end
endmodule

// File: doc/spi_reg_responder.md
Name: spi_reg_responder

Overview:
- SPI mode-0 responder (slave) giving an external SPI initiator byte-wide read/write access to a 128-entry register space.
- Counterpart to the SPI initiator used for configuration-flash access. Lets a host controller read and write motor-board registers over the same four-wire bus style.
- SPI pins are oversampled in the system clock domain; there is no SCK clock domain.
- Register side is a simple single-cycle strobe interface.

Parameters:
- ADDR_W, 7, register address width. The command byte carries bit7 = R/nW and bits[6:0] = address.
- SYNC_STAGES, 2, flip-flop synchroniser depth on spi_sck, spi_cs_n and spi_mosi.

Ports:
- clk  in  1  system clock, 48 MHz. spi_sck must not exceed clk/8.
- reset_n  in  1  asynchronous active-low reset.
- spi_sck  in  1  SPI clock from the initiator, idle low (mode 0).
- spi_cs_n  in  1  chip select, active low.
- spi_mosi  in  1  serial data in, MSB first.
- spi_miso  out  1  serial data out, MSB first.
- spi_miso_oe  out  1  MISO tristate enable. High only while selected.
- reg_addr  out  ADDR_W  register address for the current access.
- reg_wr_en  out  1  one-cycle write strobe.
- reg_wr_data  out  8  write data, valid with reg_wr_en.
- reg_rd_en  out  1  one-cycle read strobe.
- reg_rd_data  in  8  read data, valid exactly 1 clk after reg_rd_en.
- busy  out  1  high while a frame is in progress.
- frame_err  out  1  one-cycle pulse when CS deasserts mid-byte.

Behaviour:
- Reset values (async): all outputs 0; state IDLE; bit counter 0; tx shift register 0; armed flag 0.
- Synchronisers: SYNC_STAGES flops on sck, cs_n and mosi, plus one history flop on sck and cs_n for edge detection.
  - Rising sck (synchronised): sample mosi.
  - Falling sck: shift the tx register.
  - Edges are acted on only while synchronised cs_n is low.
- Arming: after reset the block ignores the bus until cs_n has been observed high for at least 1 clk. A frame already in progress at reset release is therefore never decoded.
- State IDLE:
  - Synchronised cs_n falling edge while armed: go to CMD, clear the bit counter, set busy=1, spi_miso_oe=1, spi_miso=0.
- State CMD:
  - Shift in 8 bits. On the 8th rising edge latch reg_addr = bits[6:0].
  - R/nW=0: go to WR.
  - R/nW=1: pulse reg_rd_en in the same clk, capture reg_rd_data into the tx shift register on the following clk, go to RD.
- State WR:
  - Each completed byte (8th rising edge) pulses reg_wr_en for 1 clk with reg_wr_data = that byte at the current reg_addr.
  - On the next clk reg_addr increments.
- State RD:
  - The MSB of the tx register is driven on spi_miso from load time. Each falling sck shifts left by one.
  - On the 8th rising edge of each byte, reg_addr increments and reg_rd_en pulses at the new address.
  - reg_rd_data is loaded into the tx register 1 clk later, which must be before the next falling sck. Guaranteed by the sck ≤ clk/8 rule.
  - mosi bits received during RD are ignored.
- Address increment wraps modulo 2^ADDR_W (0x7F -> 0x00). Wrap is silent.
- Frame end (synchronised cs_n rising edge, from any state): return to IDLE; busy=0, spi_miso_oe=0, spi_miso=0.
  - If the bit counter is nonzero, pulse frame_err for 1 clk and discard the partial byte; no wr strobe is issued.
  - A write strobe completed on the same clk as the cs_n rising edge is still issued.
- CS glitch shorter than the synchroniser depth: may be missed entirely. That is acceptable.
- reg_wr_en and reg_rd_en are never high in the same clk.
- Latency: reg_wr_en asserts SYNC_STAGES+2 clk after the raw 8th rising sck edge.
- reset_n asserted mid-frame: immediate return to reset values; spi_miso_oe drops asynchronously.

Decomposition:
- Shared package spi_reg_pkg:
  - state enum (IDLE, CMD, WR, RD);
  - CMD_READ_BIT = 7;
  - default ADDR_W.
- One natural sub-module, spi_pin_sync: the synchronisers plus edge detectors, producing sck_rise, sck_fall, cs_fall, cs_rise and mosi_s. Used for all three inputs.
- Remainder (FSM, shift registers, address counter) lives in spi_reg_responder.

Test Plan:
- Write burst, sck = clk/8: CS low, bytes 0x05, 0xA5, 0x3C, CS high -> reg_wr_en pulses with (addr 0x05, data 0xA5) then (addr 0x06, data 0x3C); frame_err stays 0; busy falls within SYNC_STAGES+2 clk.
- Read burst: model returns data = addr ^ 0xFF. Send 0x90 then clock 2 dummy bytes -> reg_rd_en at addr 0x10, 0x11, 0x12; MISO shows 0xEF then 0xEE, MSB first, stable on rising sck.
- Wrap: write command to addr 0x7F with 2 data bytes -> writes land at 0x7F then 0x00.
- Abort: CS high after 5 bits of the second data byte -> exactly one reg_wr_en (first byte), one frame_err pulse, spi_miso_oe=0, state IDLE.
- Reset mid-frame: assert reset_n low during the RD shift, release with CS still low, keep clocking -> no strobes, miso_oe=0. After CS goes high and a new frame starts, normal decode resumes.
- Back-to-back frames with 1 clk-period gap longer than sync depth -> both frames decoded, address restarts from the new command byte.
